delay_line_ctrl: RTL
====================

Name: delay_line_ctrl

Overview:
Sequencing controller for a block-RAM delay line. The RAM is an external simple dual-port primitive with separate write and read ports, one clock, and 1-cycle read latency. The controller owns the write and read pointers, the runtime-programmable delay length, the fill/run state machine and the sample-valid handshake. It turns a bare dual-port RAM into a streaming delay of LEN samples, where samples are counted by accepted inputs, not by clock cycles. It sits between a sample source (ADC/FIR front end) and downstream DSP that needs aligned, delayed copies.

Parameters:
DATA_WIDTH, 25, sample width in bits.
ADDR_WIDTH, 9, RAM address width; ring depth is 2^ADDR_WIDTH.
MAX_LEN, 511, largest legal delay; must be at most 2^ADDR_WIDTH-1.

Ports:
clk  in  1  single clock; all logic on its rising edge.
rst_n  in  1  asynchronous active-low reset.
len_i  in  ADDR_WIDTH+1  requested delay in samples; legal range 1..MAX_LEN.
len_load  in  1  1-cycle strobe; latch len_i and restart the fill.
di  in  DATA_WIDTH  input sample.
di_valid  in  1  input sample strobe; accepted only when ready_o=1.
ready_o  out  1  controller can accept a sample this cycle.
data_o  out  DATA_WIDTH  delayed sample.
data_valid_o  out  1  data_o is valid this cycle.
cfg_err_o  out  1  1-cycle pulse when len_load carries an illegal length.
busy_o  out  1  high in FILL.
ram_wraddr  out  ADDR_WIDTH  RAM write address.
ram_we  out  1  RAM write enable.
ram_wdata  out  DATA_WIDTH  RAM write data; equals di.
ram_rdaddr  out  ADDR_WIDTH  RAM read address.
ram_re  out  1  RAM read enable.
ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_re.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, wp=0, len_q=0, fill_cnt=0.
  - ready_o, data_valid_o, cfg_err_o, busy_o, ram_we, ram_re all 0.
  - data_o=0.
- States:
  - IDLE: ready_o=0; waits for the first legal len_load.
  - FILL: ready_o=1, busy_o=1; each accepted sample is written, and fill_cnt increments.
    - The sample accepted while fill_cnt==len_q also launches a read, and the state moves to RUN.
  - RUN: ready_o=1; each accepted sample writes and reads in the same cycle.
- Accepted sample (di_valid & ready_o):
  - ram_we=1, ram_wraddr=wp, wp<=wp+1 (modulo 2^ADDR_WIDTH, natural wrap).
  - Read address: ram_rdaddr=wp-len_q modulo 2^ADDR_WIDTH; ram_re=1 only in RUN or on the FILL->RUN transition sample.
  - Because len_q<=2^ADDR_WIDTH-1, the read and write addresses never collide.
- Output latency:
  - data_valid_o=1 exactly one cycle after a cycle with ram_re=1; data_o=ram_rdata, passed combinationally through a registered-valid path.
  - Otherwise data_valid_o=0, and data_o holds its last value.
- Delay semantics: output k equals the input accepted len_q samples earlier. The first valid output (input #0) appears one cycle after input #len_q (0-based) is accepted.
- Gaps in di_valid stall everything: no read, no valid, pointers hold.
- len_load with legal len_i (any state):
  - len_q<=len_i, fill_cnt<=0, state<=FILL.
  - wp is retained; stale RAM contents are never output.
  - ready_o is forced to 0 in the load cycle, so no sample is accepted there.
  - A data_valid_o already in flight from the previous cycle still completes.
- len_load with illegal len_i (0 or >MAX_LEN):
  - cfg_err_o pulses next cycle.
  - State, len_q and pointers are unchanged.
- Mid-operation asynchronous reset: all outputs drop to their reset values immediately; RAM contents are irrelevant.
- fill_cnt width is ADDR_WIDTH+1 and saturates at len_q.

Decomposition:
- Package delay_line_pkg holds:
  - the state encoding (IDLE, FILL, RUN);
  - default DATA_WIDTH and ADDR_WIDTH;
  - a length-legality check function.
- One natural sub-module, delay_line_addr_gen, covers wp, the read-address subtraction and wrap.
- The FSM, handshake and valid pipeline stay in the top level.
- The RAM is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then len_load len_i=4; stream 0,1,2,... every cycle → first data_valid_o one cycle after sample 4 is accepted, data_o=0; then 1,2,3 on consecutive cycles.
- len=3, di_valid asserted every other cycle with values 10,11,12,... → outputs 10,11,... each one cycle after inputs 13,14,...; no valid in the gap cycles.
- In RUN with len=8, len_load len_i=2 → ready_o low for 1 cycle, busy_o high; the next valid output equals the 1st sample after the load, appearing after the 3rd post-load sample.
- len_load with len_i=0, then with len_i=512 → cfg_err_o pulses each time; delay of 4 unchanged and output stream uninterrupted.
- len=511, stream 1200 incrementing samples → every output equals input-511 across two wp wraps; no read/write address collision flagged by the RAM model.
- Assert rst_n=0 asynchronously mid-RUN → data_valid_o, ready_o, ram_we, ram_re at 0 before the next edge; state IDLE; no output until a new len_load.

Source files
------------

// File: rtl/delay_line_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_pkg
// Description : Shared state encoding, default widths and the length-legality
//               helper for the block-RAM delay-line controller.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_line_pkg;

    localparam int c_default_data_width = 25;
    localparam int c_default_addr_width = 9;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

    function automatic logic len_is_legal(input logic [31:0] len, input logic [31:0] max_len);
        return (len != 32'd0) && (len <= max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_addr_gen
// Description : Ring write pointer and the delayed read address derived from
//               it; both wrap naturally at 2^ADDR_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_addr_gen #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] len_q,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr
);

    logic [ADDR_WIDTH-1:0] r_wp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
        end else if (advance) begin
            r_wp <= r_wp + ADDR_WIDTH'(1);
        end
    end

    assign wr_addr = r_wp;
    // Modular subtraction lands on the slot written len_q accepted samples ago.
    assign rd_addr = r_wp - len_q;

endmodule
`default_nettype wire

// File: rtl/delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_ctrl
// Description : Sequencing controller turning an external 1-cycle-latency
//               dual-port RAM into a programmable streaming sample delay.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int ADDR_WIDTH = c_default_addr_width,
    parameter int MAX_LEN    = 511
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  len_load,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  di_valid,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  cfg_err_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] ram_wraddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_rdaddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    if (MAX_LEN > (1 << ADDR_WIDTH) - 1) begin : g_max_len_check
        $error("MAX_LEN must not exceed 2^ADDR_WIDTH-1");
    end

    logic [1:0]            r_state;
    logic [ADDR_WIDTH:0]   r_len_q;
    logic [ADDR_WIDTH:0]   r_fill_cnt;
    logic                  r_valid;
    logic                  r_cfg_err;
    logic [DATA_WIDTH-1:0] r_data_q;

    logic w_len_legal;
    logic w_load_ok;
    logic w_load_bad;
    logic w_active;
    logic w_accept;
    logic w_fill_done;

    assign w_len_legal = len_is_legal(32'(len_i), 32'(MAX_LEN));
    assign w_load_ok   = len_load & w_len_legal;
    assign w_load_bad  = len_load & ~w_len_legal;
    assign w_active    = (r_state == c_st_fill) || (r_state == c_st_run);
    assign w_fill_done = (r_state == c_st_fill) && (r_fill_cnt == r_len_q);

    // A legal reload owns the cycle, so no sample slips in under the old length.
    assign ready_o  = w_active & ~w_load_ok;
    assign w_accept = di_valid & ready_o;
    assign busy_o   = (r_state == c_st_fill);

    assign ram_we    = w_accept;
    assign ram_wdata = di;
    assign ram_re    = w_accept & ((r_state == c_st_run) | w_fill_done);

    delay_line_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (w_accept),
        .len_q   (r_len_q[ADDR_WIDTH-1:0]),
        .wr_addr (ram_wraddr),
        .rd_addr (ram_rdaddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_len_q    <= '0;
            r_fill_cnt <= '0;
        end else if (w_load_ok) begin
            r_state    <= c_st_fill;
            r_len_q    <= len_i;
            r_fill_cnt <= '0;
        end else if (w_accept && (r_state == c_st_fill)) begin
            // fill_cnt stops at len_q; the sample that meets it starts reading.
            if (w_fill_done) begin
                r_state <= c_st_run;
            end else begin
                r_fill_cnt <= r_fill_cnt + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_cfg_err <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid   <= ram_re;
            r_cfg_err <= w_load_bad;
            if (r_valid) begin
                r_data_q <= ram_rdata;
            end
        end
    end

    assign data_valid_o = r_valid;
    assign cfg_err_o    = r_cfg_err;
    assign data_o       = r_valid ? ram_rdata : r_data_q;

endmodule
`default_nettype wire
